// File: rtl/u_dac_play_if.sv
// Processor-side register/RAM bus for the DAC playback engine.
// Ports: i_cs/i_we single-cycle strobes, i_addr byte address, i_data write data, o_data registered read data.
// Latency: read data two edges after the address is sampled. Backpressure: none, every strobe is accepted.
interface u_dac_play_if;
  logic        i_cs;
  logic        i_we;
  logic [15:0] i_addr;
  logic [15:0] i_data;
  logic [15:0] o_data;

  modport master (output i_cs, i_we, i_addr, i_data, input o_data);
  modport slave  (input i_cs, i_we, i_addr, i_data, output o_data);
endinterface

// File: rtl/u_dac_play.sv
// Waveform playback: bus-loaded sample RAM streamed to the DAC after arm + sync edge (or immediately), once or looped.
// Latency: play address -> o_dac_data in 2 cycles; sync pin -> first sample 5 cycles after it lands in the synchroniser.
// Backpressure: none; the DAC consumes one sample per clock and bus accesses always complete.
// Ports: i_clk/i_clr_n clock and async active-low reset; bus (slave modport) register/RAM access;
//        i_sync external trigger; o_dac_data/o_dac_valid sample stream; o_busy state!=IDLE; tst debug {valid,trig,state}.
module u_dac_play #(
  parameter int          DW        = 14,
  parameter int          AW        = 11,
  parameter logic [15:0] CHECK_VAL = 16'hd5d5
) (
  input  logic          i_clk,
  input  logic          i_clr_n,
  u_dac_play_if.slave   bus,
  input  logic          i_sync,
  output logic [DW-1:0] o_dac_data,
  output logic          o_dac_valid,
  output logic          o_busy,
  output logic [3:0]    tst
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_PLAY  = 2'd2
  } state_e;

  localparam logic [5:0] OFF_CONF = 6'd0;
  localparam logic [5:0] OFF_LEN  = 6'd1;
  localparam logic [5:0] OFF_STAT = 6'd2;
  localparam logic [5:0] OFF_CHK  = 6'd3;
  localparam logic [5:0] OFF_CTRL = 6'd4;
  localparam logic [5:0] OFF_IDLE = 6'd5;

  // Mid-scale code: reset idle level and the MSB-invert mask are the same bit.
  localparam logic [DW-1:0] MSB_BIT = {1'b1, {(DW-1){1'b0}}};

  // ---------------------------------------------------------------- decode
  logic          wr_en;
  logic          rd_en;
  logic          is_ram;
  logic          is_reg;
  logic [5:0]    reg_off;
  logic [AW-1:0] ram_addr;
  logic          arm;
  logic          stop;

  assign wr_en    = bus.i_cs & bus.i_we;
  assign rd_en    = bus.i_cs & ~bus.i_we;
  assign is_ram   = (bus.i_addr[15:14] == 2'b10);
  assign is_reg   = (bus.i_addr[15:14] == 2'b00) && (bus.i_addr[13:12] == 2'b10);
  assign reg_off  = bus.i_addr[6:1];
  assign ram_addr = bus.i_addr[AW:1];

  // CTRL bits are pulses: they act on the FSM in the write cycle and are never stored.
  assign arm  = wr_en && is_reg && (reg_off == OFF_CTRL) && bus.i_data[0];
  assign stop = wr_en && is_reg && (reg_off == OFF_CTRL) && bus.i_data[1];

  // ---------------------------------------------------------------- config registers
  logic [3:0]    conf_q;
  logic [AW-1:0] len_q;
  logic [DW-1:0] idle_q;

  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      conf_q <= '0;
      len_q  <= '1;
      idle_q <= MSB_BIT;
    end else if (wr_en && is_reg) begin
      case (reg_off)
        OFF_CONF: conf_q <= bus.i_data[3:0];
        OFF_LEN:  len_q  <= bus.i_data[AW-1:0];
        OFF_IDLE: idle_q <= bus.i_data[DW-1:0];
        default:  ;
      endcase
    end
  end

  // ---------------------------------------------------------------- trigger
  // z_sync[0] is the metastability stage; edges are judged on [1] vs [2].
  // The trigger is registered, so it is seen by the FSM one cycle after the edge is detected.
  logic [2:0] z_sync_q;
  logic       trig_q;
  logic       sync_rise;
  logic       sync_fall;

  assign sync_rise =  z_sync_q[1] & ~z_sync_q[2];
  assign sync_fall = ~z_sync_q[1] &  z_sync_q[2];

  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      z_sync_q <= '0;
      trig_q   <= 1'b0;
    end else begin
      z_sync_q <= {z_sync_q[1:0], i_sync};
      trig_q   <= conf_q[1] ? sync_rise : sync_fall;
    end
  end

  // ---------------------------------------------------------------- play FSM
  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          done_q, done_d;

  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    done_d  = done_q;
    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm) begin
            done_d = 1'b0;
            if (conf_q[2]) begin
              state_d = ST_PLAY;
              addr_d  = '0;
            end else begin
              state_d = ST_ARMED;
            end
          end
        end
        ST_ARMED: begin
          if (trig_q) begin
            state_d = ST_PLAY;
            addr_d  = '0;
          end
        end
        ST_PLAY: begin
          // LEN is compared live, so a lowered LEN ends/wraps on the next cycle.
          if (conf_q[0] && trig_q) begin
            addr_d = '0;
          end else if (addr_q >= len_q) begin
            if (conf_q[0]) begin
              addr_d = '0;
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- sample RAM
  // Bus port reads/writes, play port reads only; contents are not reset.
  logic [15:0] mem [0:(1<<AW)-1];
  logic [15:0] bus_rd_q;
  logic [15:0] play_rd_q;

  always_ff @(posedge i_clk) begin
    if (wr_en && is_ram) begin
      mem[ram_addr] <= bus.i_data;
    end
    bus_rd_q  <= mem[ram_addr];
    play_rd_q <= mem[addr_q];
  end

  // ---------------------------------------------------------------- bus read path
  // Stage 1 latches the decode alongside the RAM read, stage 2 muxes into o_data,
  // so registers and RAM share the same two-edge read latency.
  logic        rd_vld_q;
  logic [3:0]  rd_seg_q;
  logic [5:0]  rd_off_q;
  logic [15:0] rd_mux;
  logic [15:0] status_w;
  logic [15:0] o_data_q;

  assign status_w = (16'(addr_q) << 5) | {13'd0, done_q, state_q};

  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      rd_vld_q <= 1'b0;
      rd_seg_q <= '0;
      rd_off_q <= '0;
      o_data_q <= '0;
    end else begin
      rd_vld_q <= rd_en;
      rd_seg_q <= bus.i_addr[15:12];
      rd_off_q <= reg_off;
      if (rd_vld_q) begin
        o_data_q <= rd_mux;
      end
    end
  end

  always_comb begin
    rd_mux = 16'h1155;
    if (rd_seg_q[3:2] == 2'b10) begin
      rd_mux = bus_rd_q;
    end else if (rd_seg_q[3:2] == 2'b00) begin
      if (rd_seg_q[1:0] == 2'b10) begin
        case (rd_off_q)
          OFF_CONF: rd_mux = {12'd0, conf_q};
          OFF_LEN:  rd_mux = 16'(len_q);
          OFF_STAT: rd_mux = status_w;
          OFF_CHK:  rd_mux = CHECK_VAL;
          OFF_CTRL: rd_mux = 16'h0000;
          OFF_IDLE: rd_mux = 16'(idle_q);
          default:  rd_mux = 16'h3333;
        endcase
      end else begin
        rd_mux = 16'h2244;
      end
    end
  end

  assign bus.o_data = o_data_q;

  // ---------------------------------------------------------------- DAC output pipeline
  // play_vld_q tracks the RAM read stage so valid lines up with the data it qualifies.
  logic          play_vld_q;
  logic          dac_vld_q;
  logic [DW-1:0] dac_dat_q;

  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      play_vld_q <= 1'b0;
      dac_vld_q  <= 1'b0;
      dac_dat_q  <= MSB_BIT;
    end else begin
      play_vld_q <= (state_q == ST_PLAY);
      dac_vld_q  <= play_vld_q;
      dac_dat_q  <= play_vld_q ? (play_rd_q[DW-1:0] ^ (conf_q[3] ? MSB_BIT : '0)) : idle_q;
    end
  end

  assign o_dac_data  = dac_dat_q;
  assign o_dac_valid = dac_vld_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign tst         = {dac_vld_q, trig_q, state_q};

  logic unused_ok;
  assign unused_ok = &{1'b0, bus.i_addr[0], play_rd_q};

endmodule

// File: tb/tb_u_dac_play.sv
module tb_u_dac_play;
  localparam int DW = 14;
  localparam int AW = 11;

  localparam logic [15:0] A_CONF = 16'h2000;
  localparam logic [15:0] A_LEN  = 16'h2002;
  localparam logic [15:0] A_STAT = 16'h2004;
  localparam logic [15:0] A_CHK  = 16'h2006;
  localparam logic [15:0] A_CTRL = 16'h2008;
  localparam logic [15:0] A_IDLE = 16'h200A;

  logic          clk   = 1'b0;
  logic          clr_n = 1'b1;
  logic          sync  = 1'b1;
  logic [DW-1:0] dac_data;
  logic          dac_valid;
  logic          busy;
  logic [3:0]    tst;

  u_dac_play_if bus_if ();

  u_dac_play #(.DW(DW), .AW(AW), .CHECK_VAL(16'hd5d5)) dut (
    .i_clk      (clk),
    .i_clr_n    (clr_n),
    .bus        (bus_if.slave),
    .i_sync     (sync),
    .o_dac_data (dac_data),
    .o_dac_valid(dac_valid),
    .o_busy     (busy),
    .tst        (tst)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ecount = 0;

  // Scoreboard state
  logic [DW-1:0] dac_q[$];
  logic [15:0]   rd_exp_q[$];
  logic [15:0]   rd_mask_q[$];
  int            rd_due_q[$];
  string         rd_name_q[$];
  logic [DW-1:0] idle_m = 14'h2000;
  int            vld_cnt = 0;
  int            first_vld = -1;
  logic [15:0]   mem_m [int];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------ monitor
  logic [DW-1:0] m_dexp;
  logic [15:0]   m_rexp, m_rmask;
  int            m_due;
  string         m_name;

  always @(negedge clk) begin
    if (dac_valid === 1'b1) begin
      vld_cnt++;
      if (first_vld < 0) first_vld = ecount;
      if (dac_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dac_extra: unexpected sample %h at edge %0d", dac_data, ecount);
      end else begin
        m_dexp = dac_q.pop_front();
        chk("dac_sample", 32'(dac_data), 32'(m_dexp));
      end
    end else begin
      chk("dac_idle", 32'({dac_valid, dac_data}), 32'({1'b0, idle_m}));
    end
    if (rd_due_q.size() != 0 && ecount >= rd_due_q[0]) begin
      m_due   = rd_due_q.pop_front();
      m_rexp  = rd_exp_q.pop_front();
      m_rmask = rd_mask_q.pop_front();
      m_name  = rd_name_q.pop_front();
      chk({m_name, "_edge"}, 32'(ecount), 32'(m_due));
      chk(m_name, 32'(bus_if.o_data & m_rmask), 32'(m_rexp & m_rmask));
    end
  end

  // ------------------------------------------------------------ stimulus helpers
  task automatic cyc1();
    @(posedge clk);
    #1;
    ecount++;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc1();
  endtask

  // Return with ecount = e-1 so the next single-cycle action is captured at edge e.
  task automatic wait_until(input int e);
    while (ecount < e - 1) cyc1();
  endtask

  function automatic logic [15:0] ram_a(input int i);
    return 16'h8000 + 16'(2 * i);
  endfunction

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    bus_if.i_cs   = 1'b1;
    bus_if.i_we   = 1'b1;
    bus_if.i_addr = a;
    bus_if.i_data = d;
    cyc1();
    bus_if.i_cs = 1'b0;
    bus_if.i_we = 1'b0;
    if (a[15:14] == 2'b10) mem_m[int'(a[AW:1])] = d;
  endtask

  task automatic rd(input string n, input logic [15:0] a, input logic [15:0] e, input logic [15:0] m);
    bus_if.i_cs   = 1'b1;
    bus_if.i_we   = 1'b0;
    bus_if.i_addr = a;
    cyc1();
    bus_if.i_cs = 1'b0;
    rd_due_q.push_back(ecount + 1);
    rd_exp_q.push_back(e);
    rd_mask_q.push_back(m);
    rd_name_q.push_back(n);
  endtask

  function automatic logic [DW-1:0] samp(input int idx, input bit inv);
    logic [15:0] w;
    w = mem_m[idx];
    return w[DW-1:0] ^ (inv ? 14'h2000 : 14'h0000);
  endfunction

  task automatic clear_counts();
    vld_cnt   = 0;
    first_vld = -1;
  endtask

  // ------------------------------------------------------------ test sequence
  initial begin
    int k, a, r, s, j, idx;
    bus_if.i_cs   = 1'b0;
    bus_if.i_we   = 1'b0;
    bus_if.i_addr = '0;
    bus_if.i_data = '0;
    #1 clr_n = 1'b0;
    cycles(3);
    clr_n = 1'b1;
    cyc1();

    // 1: reset values and address map
    chk("rst_dac_data", 32'(dac_data), 32'h2000);
    chk("rst_valid", 32'(dac_valid), 32'h0);
    chk("rst_tst", 32'(tst), 32'h0);
    chk("rst_odata", 32'(bus_if.o_data), 32'h0);
    rd("chk_reg", A_CHK, 16'hd5d5, 16'hffff);
    rd("len_rst", A_LEN, 16'h07ff, 16'hffff);
    rd("idle_rst", A_IDLE, 16'h2000, 16'hffff);
    rd("conf_rst", A_CONF, 16'h0000, 16'hffff);
    rd("stat_rst", A_STAT, 16'h0000, 16'hffff);
    rd("ctrl_rd", A_CTRL, 16'h0000, 16'hffff);
    rd("sub_unmapped", 16'h1000, 16'h2244, 16'hffff);
    rd("top_unmapped", 16'h4000, 16'h1155, 16'hffff);
    wr(A_IDLE, 16'h1234);
    cyc1();
    idle_m = 14'h1234;
    rd("idle_rb", A_IDLE, 16'h1234, 16'hffff);
    cycles(3);
    wr(A_IDLE, 16'h2000);
    cyc1();
    idle_m = 14'h2000;

    // 2: one-shot on falling sync edge
    for (int i = 0; i < 4; i++) wr(ram_a(i), 16'(i + 1));
    rd("ram_rb", ram_a(2), 16'h0003, 16'hffff);
    wr(A_LEN, 16'd3);
    wr(A_CONF, 16'd0);
    for (int i = 0; i < 4; i++) dac_q.push_back(samp(i, 1'b0));
    clear_counts();
    wr(A_CTRL, 16'h0001);
    chk("armed_busy", 32'(busy), 32'h1);
    chk("armed_state", 32'(tst[1:0]), 32'h1);
    cycles(3);
    chk("armed_hold", 32'(tst[1:0]), 32'h1);
    sync = 1'b0;
    cyc1();
    k = ecount;
    cycles(12);
    chk("t2_latency", 32'(first_vld), 32'(k + 5));
    chk("t2_vld_cnt", 32'(vld_cnt), 32'd4);
    chk("t2_q_empty", 32'(dac_q.size()), 32'd0);
    chk("t2_busy", 32'(busy), 32'h0);
    rd("t2_status", A_STAT, 16'h0004, 16'h0007);

    // 3: continuous, immediate, restart on sync, stop
    sync = 1'b1;
    wr(ram_a(0), 16'd10);
    wr(ram_a(1), 16'd20);
    wr(ram_a(2), 16'd30);
    wr(A_LEN, 16'd2);
    wr(A_CONF, 16'd5);
    cycles(3);
    clear_counts();
    wr(A_CTRL, 16'h0001);
    a = ecount;
    chk("imm_play", 32'(tst[1:0]), 32'h2);
    r = a + 10;
    s = a + 15;
    for (int e = a; e < s; e++) begin
      idx = (e < r) ? (e - a) % 3 : (e - r) % 3;
      dac_q.push_back(samp(idx, 1'b0));
    end
    wait_until(a + 7);
    sync = 1'b0;
    cyc1();
    wait_until(s);
    wr(A_CTRL, 16'h0002);
    chk("stop_idle", 32'(tst[1:0]), 32'h0);
    cycles(6);
    chk("t3_vld_cnt", 32'(vld_cnt), 32'd15);
    chk("t3_q_empty", 32'(dac_q.size()), 32'd0);
    rd("t3_status", A_STAT, 16'h0000, 16'h0007);

    // 4: MSB invert, rising-edge sync only
    sync = 1'b1;
    cycles(4);
    wr(ram_a(0), 16'h0000);
    wr(ram_a(1), 16'h2005);
    wr(A_LEN, 16'd1);
    wr(A_CONF, 16'd10);
    dac_q.push_back(samp(0, 1'b1));
    dac_q.push_back(samp(1, 1'b1));
    clear_counts();
    wr(A_CTRL, 16'h0001);
    sync = 1'b0;
    cycles(8);
    chk("fall_ignored", 32'(tst[1:0]), 32'h1);
    chk("fall_no_out", 32'(vld_cnt), 32'd0);
    sync = 1'b1;
    cyc1();
    k = ecount;
    cycles(10);
    chk("t4_latency", 32'(first_vld), 32'(k + 5));
    chk("t4_vld_cnt", 32'(vld_cnt), 32'd2);
    chk("t4_q_empty", 32'(dac_q.size()), 32'd0);

    // 5: arm+stop together, then async reset mid-play
    wr(A_CONF, 16'd4);
    wr(A_CTRL, 16'h0003);
    chk("armstop_state", 32'(tst[1:0]), 32'h0);
    chk("armstop_busy", 32'(busy), 32'h0);
    cycles(3);
    chk("armstop_hold", 32'(tst[1:0]), 32'h0);
    wr(A_LEN, 16'd2);
    wr(A_CONF, 16'd5);
    clear_counts();
    wr(A_CTRL, 16'h0001);
    a = ecount;
    for (int e = a; e < a + 5; e++) dac_q.push_back(samp((e - a) % 3, 1'b0));
    while (ecount < a + 6) cyc1();
    @(negedge clk);
    #1;
    clr_n  = 1'b0;
    idle_m = 14'h2000;
    #1;
    chk("rst_mid_valid", 32'(dac_valid), 32'h0);
    chk("rst_mid_state", 32'(tst[1:0]), 32'h0);
    chk("rst_mid_data", 32'(dac_data), 32'h2000);
    chk("t5_vld_cnt", 32'(vld_cnt), 32'd5);
    chk("t5_q_empty", 32'(dac_q.size()), 32'd0);
    cycles(2);
    clr_n = 1'b1;
    cycles(2);

    // 6: live LEN lowered during continuous play
    for (int i = 0; i < 8; i++) wr(ram_a(i), 16'(100 + i));
    wr(A_LEN, 16'd7);
    wr(A_CONF, 16'd5);
    clear_counts();
    wr(A_CTRL, 16'h0001);
    a = ecount;
    s = a + 14;
    for (int e = a; e < s; e++) begin
      j = e - a;
      idx = (j <= 6) ? j : (j - 7) % 3;
      dac_q.push_back(samp(idx, 1'b0));
    end
    wait_until(a + 6);
    wr(A_LEN, 16'd2);
    wait_until(s);
    wr(A_CTRL, 16'h0002);
    cycles(6);
    chk("t6_vld_cnt", 32'(vld_cnt), 32'd14);
    chk("t6_q_empty", 32'(dac_q.size()), 32'd0);
    rd("len_rb", A_LEN, 16'h0002, 16'hffff);
    rd("off_unmapped7", 16'h200E, 16'h3333, 16'hffff);
    rd("off_unmapped63", 16'h207E, 16'h3333, 16'hffff);
    rd("ram_rb5", ram_a(5), 16'd105, 16'hffff);
    cycles(4);
    chk("rd_pending", 32'(rd_due_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
